// File: rtl/lmdpl_output_decoder_if.sv
// Bus between the LMDPL gadget chain output and the unmasked consumer.
// The slave view belongs to the decoder; the master view drives rails and consumes words.
interface lmdpl_output_decoder_if #(
  parameter int WIDTH = 8
);
  logic             pre;
  logic [WIDTH-1:0] din_t;
  logic [WIDTH-1:0] din_f;
  logic [WIDTH-1:0] din_m;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             fault;
  logic [1:0]       fault_code;
  logic             overflow;
  logic             clr_fault;

  modport master (
    output pre, din_t, din_f, din_m, dout_ready, clr_fault,
    input  dout, dout_valid, fault, fault_code, overflow
  );

  modport slave (
    input  pre, din_t, din_f, din_m, dout_ready, clr_fault,
    output dout, dout_valid, fault, fault_code, overflow
  );
endinterface

// File: rtl/lmdpl_output_decoder.sv
// LMDPL bus receiver: follows the precharge/evaluate protocol, flags rail faults,
// unmasks completed words and offers them over a one-deep valid/ready buffer.
module lmdpl_output_decoder #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         Po_rst,
  lmdpl_output_decoder_if.slave        bus
);

  typedef enum logic [1:0] {WAIT_PRE, ARMED, EVAL, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  localparam logic [1:0] CODE_RAIL    = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;
  localparam logic [1:0] CODE_PRECHG  = 2'b11;

  function automatic logic [WIDTH-1:0] unmask(input logic [WIDTH-1:0] t,
                                              input logic [WIDTH-1:0] m);
    return t ^ m;
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic             overflow_q, overflow_d;

  logic             all_done, any_bad, idle, xfer;
  logic             capture, new_fault;
  logic [1:0]       new_code;

  assign all_done = &(bus.din_t ^ bus.din_f);
  assign any_bad  = |(bus.din_t & bus.din_f);
  assign idle     = ~|(bus.din_t | bus.din_f);
  assign xfer     = dout_valid_q & bus.dout_ready;

  always_ff @(posedge clk or posedge Po_rst) begin
    if (Po_rst) begin
      state_q      <= WAIT_PRE;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      overflow_q   <= overflow_d;
    end
  end

  // Protocol tracking: decides transitions, capture requests and fault events.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    new_fault = 1'b0;
    new_code  = 2'b00;
    unique case (state_q)
      WAIT_PRE: begin
        if (bus.pre && idle) state_d = ARMED;
      end
      ARMED: begin
        if (bus.pre && !idle) begin
          new_fault = 1'b1;
          new_code  = CODE_PRECHG;
          state_d   = WAIT_PRE;
        end else if (!bus.pre) begin
          state_d = EVAL;
          cnt_d   = '0;
        end
      end
      EVAL: begin
        if (any_bad) begin
          new_fault = 1'b1;
          new_code  = CODE_RAIL;
          state_d   = WAIT_PRE;
        end else if (bus.pre) begin
          new_fault = 1'b1;
          new_code  = CODE_PRECHG;
          state_d   = WAIT_PRE;
        end else if (all_done) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_C) begin
          new_fault = 1'b1;
          new_code  = CODE_TIMEOUT;
          state_d   = WAIT_PRE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (any_bad) begin
          new_fault = 1'b1;
          new_code  = CODE_RAIL;
          state_d   = WAIT_PRE;
        end else if (bus.pre && idle) begin
          state_d = ARMED;
        end else if (bus.pre) begin
          state_d = WAIT_PRE;
        end
      end
      default: state_d = WAIT_PRE;
    endcase
  end

  // Output buffer and sticky status; a capture may refill the slot being drained.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    overflow_d   = overflow_q;

    if (capture && (!dout_valid_q || bus.dout_ready)) begin
      dout_d       = unmask(bus.din_t, bus.din_m);
      dout_valid_d = 1'b1;
    end else begin
      if (xfer) dout_valid_d = 1'b0;
      if (capture) overflow_d = 1'b1;
      else if (bus.clr_fault) overflow_d = 1'b0;
    end

    // A same-cycle clear makes the incoming fault the first one.
    if (new_fault) begin
      fault_d      = 1'b1;
      fault_code_d = (fault_q && !bus.clr_fault) ? fault_code_q : new_code;
    end else if (bus.clr_fault) begin
      fault_d      = 1'b0;
      fault_code_d = 2'b00;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.overflow   = overflow_q;

endmodule
